// File: rtl/md_pkg.sv
// Shared types for the EX-stage multiply/divide unit:
// op encodings, default latencies and FSM states.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_div_op(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath on the latched
// op and operands; flags a divide by zero.
module md_arith
  import md_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_zero
);

  logic        sgn;
  logic [63:0] prod;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] dvs;
  logic [31:0] q;
  logic [31:0] r;
  logic        neg_q;
  logic        neg_r;

  // Divide on magnitudes, then fix signs: avoids the
  // INT_MIN / -1 overflow of a native signed divide.
  always_comb begin
    sgn      = (op == MD_MULT) || (op == MD_DIV);
    prod     = sgn ? {{32{a[31]}}, a} * {{32{b[31]}}, b}
                   : {32'd0, a} * {32'd0, b};
    abs_a    = (sgn && a[31]) ? -a : a;
    abs_b    = (sgn && b[31]) ? -b : b;
    div_zero = is_div_op(op) && (b == 32'd0);
    dvs      = (b == 32'd0) ? 32'd1 : abs_b;
    q        = abs_a / dvs;
    r        = abs_a % dvs;
    neg_q    = sgn && (a[31] ^ b[31]);
    neg_r    = sgn && a[31];
    if (is_div_op(op)) begin
      hi_res = neg_r ? -r : r;
      lo_res = neg_q ? -q : q;
    end else begin
      hi_res = prod[63:32];
      lo_res = prod[31:0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: fixed-latency FSM,
// operand latches and the architectural HI/LO pair.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = 8;

  md_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  md_op_t      op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  md_op_t      op_in;
  logic        is_md;
  logic [31:0] hi_res;
  logic [31:0] lo_res;
  logic        div_zero;

  assign op_in = md_op_t'(md_op);
  assign is_md = (op_in == MD_MULT) || (op_in == MD_MULTU)
              || is_div_op(op_in);

  md_arith u_arith (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .hi_res   (hi_res),
    .lo_res   (lo_res),
    .div_zero (div_zero)
  );

  // Next state: accept ops in IDLE, count down in RUN,
  // commit the result on the last busy cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start && is_md) begin
          op_d    = op_in;
          a_d     = rs_val;
          b_d     = rt_val;
          cnt_d   = is_div_op(op_in) ? CW'(DIV_CYCLES)
                                     : CW'(MULT_CYCLES);
          state_d = RUN;
        end else if (!start) begin
          if (op_in == MD_MTHI) hi_d = rs_val;
          if (op_in == MD_MTLO) lo_d = rs_val;
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!div_zero) begin
            hi_d = hi_res;
            lo_d = lo_res;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, operand latches and HI/LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Read-out mux for mfhi/mflo.
  always_comb begin
    md_out = '0;
    if (op_in == MD_MFHI) md_out = hi_q;
    if (op_in == MD_MFLO) md_out = lo_q;
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + random scoreboard bench for mult_div_unit
// with an independent longint reference model.
module tb_mult_div_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] sb[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .md_op   (md_op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .busy    (busy),
    .md_out  (md_out),
    .hi      (hi),
    .lo      (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(
    input md_op_t op, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] oh,
    input logic [31:0] ol);
    longint sa, sb2, q, r;
    longint unsigned ua, ub, p;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (op)
      MD_MULT:  begin
        q = sa * sb2;
        return q;
      end
      MD_MULTU: begin
        p = ua * ub;
        return p;
      end
      MD_DIV: begin
        if (b == 32'd0) return {oh, ol};
        q = sa / sb2;
        r = sa % sb2;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (b == 32'd0) return {oh, ol};
        p = ua / ub;
        ua = ua % ub;
        return {ua[31:0], p[31:0]};
      end
      default: return {oh, ol};
    endcase
  endfunction

  // Caller sits just after a negedge; returns at the
  // negedge where busy has dropped.
  task automatic run_op(input md_op_t op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input bit poke);
    int n;
    logic [63:0] e;
    n = is_div_op(op) ? 10 : 5;
    sb.push_back(model(op, a, b, m_hi, m_lo));
    md_op  = op;
    rs_val = a;
    rt_val = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    md_op  = MD_NONE;
    rs_val = $urandom;
    rt_val = $urandom;
    for (int i = 1; i <= n; i++) begin
      check("busy_run", {31'd0, busy}, 32'd1);
      if (poke && i == 2) begin
        md_op  = MD_MTHI;
        rs_val = 32'hDEAD;
      end
      if (poke && i == 3) begin
        check("mthi_busy", hi, m_hi);
        md_op = MD_NONE;
      end
      @(negedge clk);
    end
    check("busy_done", {31'd0, busy}, 32'd0);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("hi_res", hi, e[63:32]);
      check("lo_res", lo, e[31:0]);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
  endtask

  task automatic mt(input md_op_t op,
                    input logic [31:0] v);
    md_op  = op;
    rs_val = v;
    start  = 1'b0;
    @(negedge clk);
    md_op = MD_NONE;
    if (op == MD_MTHI) m_hi = v;
    if (op == MD_MTLO) m_lo = v;
  endtask

  initial begin
    md_op_t rop;
    logic [31:0] ra, rb;
    reset_n = 1'b0;
    start   = 1'b0;
    md_op   = MD_NONE;
    rs_val  = 32'd0;
    rt_val  = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_mdout", md_out, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
    run_op(MD_DIVU, 32'd7, 32'd2, 1'b0);
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);

    mt(MD_MTHI, 32'h11);
    mt(MD_MTLO, 32'h22);
    check("mthi_idle", hi, 32'h11);
    check("mtlo_idle", lo, 32'h22);
    run_op(MD_DIV, 32'd5, 32'd0, 1'b1);

    mt(MD_MTLO, 32'hABCD);
    check("mtlo_lo", lo, 32'hABCD);
    md_op = MD_MFLO;
    #1 check("mflo_out", md_out, 32'hABCD);
    md_op = MD_MFHI;
    #1 check("mfhi_out", md_out, m_hi);
    md_op = MD_NONE;
    #1 check("none_out", md_out, 32'd0);

    md_op = MD_MFHI;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    md_op = MD_NONE;
    check("start_ign", {31'd0, busy}, 32'd0);

    for (int k = 0; k < 6; k++) begin
      rop = md_op_t'(4'($urandom_range(1, 4)));
      ra  = $urandom;
      rb  = (k == 3) ? 32'd0 : 32'($urandom);
      run_op(rop, ra, rb, 1'b0);
    end

    mt(MD_MTHI, 32'h5A5A);
    md_op  = MD_MULT;
    rs_val = 32'd3;
    rt_val = 32'd4;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    md_op = MD_NONE;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_hi", hi, m_hi);
    check("post_lo", lo, m_lo);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
